// File: rtl/axis_forward_ctrl.sv
// Frame sequencer for the VAE forward datapath: loads one AXIS parameter frame,
// starts the datapath, waits for done (with timeout) and streams results out.
module axis_forward_ctrl #(
  parameter int N_IN_BEATS  = 19,
  parameter int N_OUT_WORDS = 9,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TLAST_CHECK = 0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [63:0]              s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [63:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     prm_we,
  output logic [4:0]               prm_addr,
  output logic [63:0]              prm_wdata,
  output logic                     dp_start,
  input  logic                     dp_done,
  input  logic [16*N_OUT_WORDS-1:0] dp_result,
  output logic                     busy,
  output logic                     err_frame,
  output logic                     err_timeout,
  output logic [1:0]               dbg_state_o
);

  localparam int N_OUT_BEATS = (N_OUT_WORDS + 3) / 4;
  localparam int OW = (N_OUT_BEATS > 1) ? $clog2(N_OUT_BEATS) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_e;

  // Handshakes: a beat moves on either stream only in a cycle where valid and
  // ready are both high at the rising edge; valid never waits on ready.
  state_e                          state_q, state_d;
  logic                            run_q;
  logic [4:0]                      cnt_q, cnt_d;
  logic [TW-1:0]                   to_cnt_q, to_cnt_d;
  logic [OW-1:0]                   out_cnt_q, out_cnt_d;
  logic [N_OUT_BEATS-1:0][63:0]    obuf_q, obuf_d;
  logic                            prm_we_q, prm_we_d;
  logic [4:0]                      prm_addr_q, prm_addr_d;
  logic [63:0]                     prm_wdata_q, prm_wdata_d;
  logic                            start_q, start_d;
  logic                            err_frame_q, err_frame_d;
  logic                            err_to_q, err_to_d;
  logic [64*N_OUT_BEATS-1:0]       res_flat;
  logic                            s_hs;

  // run_q keeps tready low until the first edge after reset release.
  assign s_axis_tready = run_q && (state_q == LOAD);
  assign s_hs          = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_cnt_d    = to_cnt_q;
    out_cnt_d   = out_cnt_q;
    obuf_d      = obuf_q;
    prm_we_d    = 1'b0;
    prm_addr_d  = prm_addr_q;
    prm_wdata_d = prm_wdata_q;
    start_d     = 1'b0;
    err_frame_d = err_frame_q;
    err_to_d    = err_to_q;
    res_flat    = '0;
    res_flat[16*N_OUT_WORDS-1:0] = dp_result;

    case (state_q)
      LOAD: begin
        if (s_hs) begin
          prm_we_d    = 1'b1;
          prm_addr_d  = cnt_q;
          prm_wdata_d = s_axis_tdata;
          if (cnt_q == 5'(N_IN_BEATS - 1)) begin
            state_d = START;
            cnt_d   = '0;
            if (TLAST_CHECK != 0 && !s_axis_tlast) err_frame_d = 1'b1;
          end else if (TLAST_CHECK != 0 && s_axis_tlast) begin
            // Early tlast drops the frame; the beat itself was already written.
            err_frame_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      START: begin
        start_d  = 1'b1;
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (dp_done) begin
          obuf_d    = res_flat;
          out_cnt_d = '0;
          state_d   = SEND;
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          err_to_d  = 1'b1;
          obuf_d    = '0;
          out_cnt_d = '0;
          state_d   = SEND;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (out_cnt_q == OW'(N_OUT_BEATS - 1)) state_d = LOAD;
          else out_cnt_d = out_cnt_q + OW'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= LOAD;
      run_q       <= 1'b0;
      cnt_q       <= '0;
      to_cnt_q    <= '0;
      out_cnt_q   <= '0;
      obuf_q      <= '0;
      prm_we_q    <= 1'b0;
      prm_addr_q  <= '0;
      prm_wdata_q <= '0;
      start_q     <= 1'b0;
      err_frame_q <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      cnt_q       <= cnt_d;
      to_cnt_q    <= to_cnt_d;
      out_cnt_q   <= out_cnt_d;
      obuf_q      <= obuf_d;
      prm_we_q    <= prm_we_d;
      prm_addr_q  <= prm_addr_d;
      prm_wdata_q <= prm_wdata_d;
      start_q     <= start_d;
      err_frame_q <= err_frame_d;
      err_to_q    <= err_to_d;
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = (state_q == SEND) ? obuf_q[out_cnt_q] : '0;
  assign m_axis_tlast  = (state_q == SEND) && (out_cnt_q == OW'(N_OUT_BEATS - 1));
  assign prm_we        = prm_we_q;
  assign prm_addr      = prm_addr_q;
  assign prm_wdata     = prm_wdata_q;
  assign dp_start      = start_q;
  assign busy          = (state_q != LOAD);
  assign err_frame     = err_frame_q;
  assign err_timeout   = err_to_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axis_forward_ctrl.sv
// Directed bench for axis_forward_ctrl: nominal frame, back-pressure, input gaps,
// timeout, early/missing tlast and mid-frame reset.
module tb_axis_forward_ctrl;
  localparam int NIB = 19;
  localparam int NOW = 9;
  localparam int NOB = 3;
  localparam int TO  = 64;

  logic                aclk = 1'b0;
  logic                aresetn;
  logic [63:0]         s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tlast;
  logic                s_axis_tready;
  logic [63:0]         m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tlast;
  logic                m_axis_tready;
  logic                prm_we;
  logic [4:0]          prm_addr;
  logic [63:0]         prm_wdata;
  logic                dp_start;
  logic                dp_done;
  logic [16*NOW-1:0]   dp_result;
  logic                busy;
  logic                err_frame;
  logic                err_timeout;
  logic [1:0]          dbg_state;

  axis_forward_ctrl #(
    .N_IN_BEATS(NIB), .N_OUT_WORDS(NOW), .TIMEOUT_CYC(TO), .TLAST_CHECK(1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .prm_we(prm_we), .prm_addr(prm_addr), .prm_wdata(prm_wdata),
    .dp_start(dp_start), .dp_done(dp_done), .dp_result(dp_result),
    .busy(busy), .err_frame(err_frame), .err_timeout(err_timeout),
    .dbg_state_o(dbg_state)
  );

  // Clock and cycle counter
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc++;

  // Scoreboard state
  logic [63:0] exp_q[$];
  logic        exp_last_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_addr = 0;
  int n_we = 0;
  int first_we_cyc = 0;
  int last_we_cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int err_to_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int i);
    logic [63:0] d;
    if (i == 0) d = 64'h0000_0100_0000_0100;
    else d = {16'(i), 16'(i * 3), 16'(i * 5), 16'(i * 7)};
    return d;
  endfunction

  // Monitor: parameter writes, start timing, output beats and AXIS hold rule
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prm_we) begin
        check("prm_addr", 64'(prm_addr), 64'(exp_addr));
        check("prm_wdata", prm_wdata, beat_data(exp_addr));
        if (exp_addr == 0) first_we_cyc = cyc;
        last_we_cyc = cyc;
        exp_addr++;
        n_we++;
      end
      if (dp_start) begin
        start_cnt++;
        start_cyc = cyc;
        check("start_after_last_we", 64'(cyc), 64'(last_we_cyc + 1));
      end
      if (err_timeout && err_to_cyc < 0) err_to_cyc = cyc;
      if (prev_stall) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'(1));
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid) check("s_ready_low_in_send", 64'(s_axis_tready), 64'(0));
      if (m_axis_tvalid && m_axis_tready) begin
        check("out_beat_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          check("out_data", m_axis_tdata, exp_q.pop_front());
          check("out_last", 64'(m_axis_tlast), 64'(exp_last_q.pop_front()));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic send_frame(input int nbeats, input int gap, input int tlast_at);
    for (int i = 0; i < nbeats; i++) begin
      bit ok;
      int w;
      s_axis_tdata  = beat_data(i);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == tlast_at);
      ok = 1'b0;
      w  = 0;
      while (!ok && w < 100) begin
        @(negedge aclk);
        ok = s_axis_tready;
        @(posedge aclk);
        #2;
        w++;
      end
      if (!ok) check("s_accept", 64'(ok), 64'(1));
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (gap != 0) tick();
    end
  endtask

  task automatic wait_start(input int target);
    int w = 0;
    while (start_cnt < target && w < 200) begin
      tick();
      w++;
    end
    check("dp_start_count", 64'(start_cnt), 64'(target));
  endtask

  // Drives dp_result word i = base+i and queues the packed beats it should produce
  task automatic set_result(input logic [15:0] base);
    for (int i = 0; i < NOW; i++) dp_result[16*i +: 16] = base + 16'(i);
    for (int j = 0; j < NOB; j++) begin
      logic [63:0] b;
      b = '0;
      for (int k = 0; k < 4; k++)
        if (4 * j + k < NOW) b[16*k +: 16] = base + 16'(4 * j + k);
      exp_q.push_back(b);
      exp_last_q.push_back(j == NOB - 1);
    end
  endtask

  task automatic pulse_done();
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
  endtask

  task automatic wait_drain(input int toggle);
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 400) begin
      tick();
      if (toggle != 0) m_axis_tready = ~m_axis_tready;
      w++;
    end
    check("drained", 64'(exp_q.size()), 64'(0));
    check("idle_after_send", 64'(busy), 64'(0));
    m_axis_tready = 1'b1;
  endtask

  int st0;
  int we0;

  initial begin
    aresetn = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; dp_done = 1'b0; dp_result = '0;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_s_tready", 64'(s_axis_tready), 64'(0));
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_m_tdata", m_axis_tdata, 64'(0));
    check("rst_m_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_prm_we", 64'(prm_we), 64'(0));
    check("rst_dp_start", 64'(dp_start), 64'(0));
    check("rst_err_frame", 64'(err_frame), 64'(0));
    check("rst_err_timeout", 64'(err_timeout), 64'(0));
    tick();
    aresetn = 1'b1;
    tick(); tick();
    check("ready_after_reset", 64'(s_axis_tready), 64'(1));
    check("state_load", 64'(dbg_state), 64'(0));

    // Nominal frame with hand-packed results
    exp_addr = 0; we0 = n_we; st0 = start_cnt;
    send_frame(NIB, 0, NIB - 1);
    wait_start(st0 + 1);
    check("nom_we_count", 64'(n_we - we0), 64'(19));
    check("nom_we_consecutive", 64'(last_we_cyc - first_we_cyc), 64'(18));
    check("nom_busy_wait", 64'(busy), 64'(1));
    check("nom_s_tready_wait", 64'(s_axis_tready), 64'(0));
    repeat (49) tick();
    dp_result = 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001;
    exp_q.push_back(64'h0004_0003_0002_0001); exp_last_q.push_back(1'b0);
    exp_q.push_back(64'h0008_0007_0006_0005); exp_last_q.push_back(1'b0);
    exp_q.push_back(64'h0000_0000_0000_0009); exp_last_q.push_back(1'b1);
    pulse_done();
    wait_drain(0);
    check("nom_err_frame", 64'(err_frame), 64'(0));
    check("nom_err_timeout", 64'(err_timeout), 64'(0));
    check("nom_ready_again", 64'(s_axis_tready), 64'(1));

    // Output back-pressure
    exp_addr = 0; st0 = start_cnt;
    send_frame(NIB, 0, NIB - 1);
    wait_start(st0 + 1);
    repeat (5) tick();
    set_result(16'hA000);
    pulse_done();
    m_axis_tready = 1'b0;
    wait_drain(1);

    // Input gaps
    exp_addr = 0; we0 = n_we; st0 = start_cnt;
    send_frame(NIB, 1, NIB - 1);
    wait_start(st0 + 1);
    check("gap_we_count", 64'(n_we - we0), 64'(19));
    check("gap_last_addr", 64'(exp_addr), 64'(19));
    set_result(16'h1230);
    pulse_done();
    wait_drain(0);
    check("gap_single_start", 64'(start_cnt), 64'(st0 + 1));

    // dp_done while idle is ignored
    dp_result = '1;
    pulse_done();
    tick();
    check("stray_done_busy", 64'(busy), 64'(0));
    check("stray_done_tvalid", 64'(m_axis_tvalid), 64'(0));

    // Timeout: no dp_done
    exp_addr = 0; st0 = start_cnt;
    send_frame(NIB, 0, NIB - 1);
    wait_start(st0 + 1);
    for (int j = 0; j < NOB; j++) begin
      exp_q.push_back(64'h0);
      exp_last_q.push_back(j == NOB - 1);
    end
    wait_drain(0);
    check("to_err_timeout", 64'(err_timeout), 64'(1));
    check("to_latency", 64'(err_to_cyc - start_cyc), 64'(TO));
    check("to_ready_again", 64'(s_axis_tready), 64'(1));

    // Early tlast drops the frame
    exp_addr = 0; st0 = start_cnt;
    send_frame(6, 0, 5);
    tick(); tick(); tick();
    check("early_tlast_err", 64'(err_frame), 64'(1));
    check("early_tlast_no_start", 64'(start_cnt), 64'(st0));
    check("early_tlast_busy", 64'(busy), 64'(0));
    check("early_tlast_writes", 64'(exp_addr), 64'(6));
    exp_addr = 0;
    send_frame(NIB, 0, NIB - 1);
    wait_start(st0 + 1);
    set_result(16'h0040);
    pulse_done();
    wait_drain(0);
    check("err_frame_sticky", 64'(err_frame), 64'(1));

    // Reset mid-frame at beat 10
    exp_addr = 0; st0 = start_cnt;
    send_frame(10, 0, -1);
    s_axis_tdata = beat_data(10);
    s_axis_tvalid = 1'b1;
    #1;
    aresetn = 1'b0;
    #1;
    check("arst_s_tready", 64'(s_axis_tready), 64'(0));
    check("arst_prm_we", 64'(prm_we), 64'(0));
    check("arst_prm_addr", 64'(prm_addr), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_err_frame", 64'(err_frame), 64'(0));
    check("arst_err_timeout", 64'(err_timeout), 64'(0));
    s_axis_tvalid = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    tick(); tick();
    check("arst_no_start", 64'(start_cnt), 64'(st0));
    check("arst_ready", 64'(s_axis_tready), 64'(1));

    // Full frame after reset, missing tlast on the last beat
    exp_addr = 0;
    send_frame(NIB, 0, -1);
    wait_start(st0 + 1);
    check("missing_tlast_err", 64'(err_frame), 64'(1));
    check("post_reset_writes", 64'(exp_addr), 64'(19));
    set_result(16'h7F00);
    pulse_done();
    wait_drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
